// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two NIBBLES x 4-bit operands one nibble per clock.
// mode 0 chains the carry across nibbles (full-width add); mode 1 treats each
// nibble as an independent lane. Optional build macro NIBBLE_SERIAL_ADDER_SAT_EN
// makes mode-1 lanes saturate to 4'hF on overflow instead of wrapping.
// busy/done are registered from the FSM state, so they trail it by one cycle.
module nibble_serial_adder #(
   parameter int unsigned NIBBLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   mode,
   input  logic [4*NIBBLES-1:0]   A,
   input  logic [4*NIBBLES-1:0]   B,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   sum,
   output logic [NIBBLES-1:0]     lane_cout,
   output logic                   carry_out
);

   localparam int unsigned W  = 4 * NIBBLES;
   localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int unsigned SW = $clog2(W);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [W-1:0]    a_q, b_q, a_d, b_d;
   logic            mode_q, mode_d;
   logic [IW-1:0]   idx, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    sum_d;
   logic [NIBBLES-1:0] lane_d;
   logic            busy_d, done_d;
   logic            last_c;
   logic [SW-1:0]   base_c;
   logic [3:0]      nib_a_c, nib_b_c, nib_s_c;
   logic            cin_c;
   logic [4:0]      t_c;

   assign last_c    = (idx == IW'(NIBBLES - 1));
   assign base_c    = SW'({idx, 2'b00});
   assign carry_out = lane_cout[NIBBLES-1];

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_RUN;
         S_RUN:   if (last_c) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Output / datapath next values: capture in IDLE, one nibble per RUN cycle
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      mode_d  = mode_q;
      idx_d   = idx;
      carry_d = carry_q;
      sum_d   = sum;
      lane_d  = lane_cout;
      nib_a_c = a_q[base_c +: 4];
      nib_b_c = b_q[base_c +: 4];
      cin_c   = mode_q ? 1'b0 : carry_q;
      t_c     = 5'(nib_a_c) + 5'(nib_b_c) + 5'(cin_c);
      nib_s_c = t_c[3:0];
`ifdef NIBBLE_SERIAL_ADDER_SAT_EN
      if (mode_q && t_c[4]) nib_s_c = 4'hF;
`endif
      busy_d  = (state != S_IDLE);
      done_d  = (state == S_DONE);
      case (state)
         S_IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               mode_d  = mode;
               idx_d   = '0;
               carry_d = 1'b0;
               sum_d   = '0;
               lane_d  = '0;
            end
         end
         S_RUN: begin
            sum_d[base_c +: 4] = nib_s_c;
            lane_d[idx]        = t_c[4];
            carry_d            = t_c[4];
            if (!last_c) idx_d = idx + IW'(1);
         end
         default: ;
      endcase
   end

   // Datapath and handshake registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         mode_q    <= 1'b0;
         idx       <= '0;
         carry_q   <= 1'b0;
         sum       <= '0;
         lane_cout <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         mode_q    <= mode_d;
         idx       <= idx_d;
         carry_q   <= carry_d;
         sum       <= sum_d;
         lane_cout <= lane_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a 2-nibble and a 4-nibble instance.
module tb_nibble_serial_adder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       start2, mode2, busy2, done2, co2;
   logic [7:0] a2, b2, sum2;
   logic [1:0] lc2;

   logic        start4, mode4, busy4, done4, co4;
   logic [15:0] a4, b4, sum4;
   logic [3:0]  lc4;

   int checks   = 0;
   int failures = 0;

   nibble_serial_adder #(.NIBBLES(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .mode(mode2), .A(a2), .B(b2),
      .busy(busy2), .done(done2), .sum(sum2), .lane_cout(lc2), .carry_out(co2));

   nibble_serial_adder #(.NIBBLES(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .mode(mode4), .A(a4), .B(b4),
      .busy(busy4), .done(done4), .sum(sum4), .lane_cout(lc4), .carry_out(co4));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Run one op on the 2-nibble DUT and check latency plus result
   task automatic op2(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic m, input logic [7:0] es, input logic [1:0] el);
      int lat;
      a2 = a; b2 = b; mode2 = m; start2 = 1'b1;
      tick;
      start2 = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         tick;
         if (done2) begin lat = k; break; end
      end
      chk({tag, "_lat"}, 32'(lat), 32'd3);
      chk({tag, "_sum"}, 32'(sum2), 32'(es));
      chk({tag, "_lc"},  32'(lc2),  32'(el));
      chk({tag, "_co"},  32'(co2),  32'(el[1]));
      tick;
      chk({tag, "_done_drop"}, 32'(done2), 32'd0);
   endtask

   // Run one op on the 4-nibble DUT and check latency plus result
   task automatic op4(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic m, input logic [15:0] es, input logic [3:0] el);
      int lat;
      a4 = a; b4 = b; mode4 = m; start4 = 1'b1;
      tick;
      start4 = 1'b0;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         tick;
         if (done4) begin lat = k; break; end
      end
      chk({tag, "_lat"}, 32'(lat), 32'd5);
      chk({tag, "_sum"}, 32'(sum4), 32'(es));
      chk({tag, "_lc"},  32'(lc4),  32'(el));
      chk({tag, "_co"},  32'(co4),  32'(el[3]));
      tick;
   endtask

   initial begin
      int dcount;
      rst = 1'b1;
      start2 = 1'b0; mode2 = 1'b0; a2 = '0; b2 = '0;
      start4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0;
      tick; tick;
      chk("rst_busy", 32'(busy2), 32'd0);
      chk("rst_done", 32'(done2), 32'd0);
      chk("rst_sum",  32'(sum2),  32'd0);
      chk("rst_lc",   32'(lc2),   32'd0);
      chk("rst_co",   32'(co2),   32'd0);
      chk("rst_sum4", 32'(sum4),  32'd0);

      // rst wins over start in the same cycle
      start2 = 1'b1; a2 = 8'h11; b2 = 8'h22;
      tick;
      rst = 1'b0; start2 = 1'b0;
      tick; tick;
      chk("rstprio_busy", 32'(busy2), 32'd0);
      chk("rstprio_sum",  32'(sum2),  32'd0);

      // Test 1: AA+55 mode 0, cycle-by-cycle
      a2 = 8'hAA; b2 = 8'h55; mode2 = 1'b0; start2 = 1'b1;
      tick;
      start2 = 1'b0;
      tick;
      chk("t1_e1_busy", 32'(busy2), 32'd1);
      chk("t1_e1_sum",  32'(sum2),  32'h0F);
      chk("t1_e1_done", 32'(done2), 32'd0);
      tick;
      chk("t1_e2_busy", 32'(busy2), 32'd1);
      chk("t1_e2_done", 32'(done2), 32'd0);
      tick;
      chk("t1_e3_busy", 32'(busy2), 32'd1);
      chk("t1_e3_done", 32'(done2), 32'd1);
      chk("t1_sum",     32'(sum2),  32'hFF);
      chk("t1_lc",      32'(lc2),   32'd0);
      chk("t1_co",      32'(co2),   32'd0);
      tick;
      chk("t1_e4_busy", 32'(busy2), 32'd0);
      chk("t1_e4_done", 32'(done2), 32'd0);
      tick;
      chk("t1_hold_sum", 32'(sum2), 32'hFF);

      // Test 2: carry ripples across nibbles
      op2("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 2'b11);

      // Test 3: independent lanes
      op2("t3a", 8'hCC, 8'h33, 1'b1, 8'hFF, 2'b00);
`ifdef NIBBLE_SERIAL_ADDER_SAT_EN
      op2("t3b", 8'hFF, 8'h01, 1'b1, 8'hFF, 2'b01);
`else
      op2("t3b", 8'hFF, 8'h01, 1'b1, 8'hF0, 2'b01);
`endif

      // Test 4: start held and operands changed while busy are ignored
      a2 = 8'h12; b2 = 8'h34; mode2 = 1'b0; start2 = 1'b1;
      tick;
      a2 = 8'hFF; b2 = 8'hFF; mode2 = 1'b1;
      dcount = 0;
      tick; dcount += int'(done2);
      tick; dcount += int'(done2);
      tick; dcount += int'(done2);
      chk("t4_done_e3", 32'(done2), 32'd1);
      chk("t4_sum",     32'(sum2),  32'h46);
      start2 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick; dcount += int'(done2);
      end
      chk("t4_done_once", 32'(dcount), 32'd1);
      chk("t4_hold_sum",  32'(sum2),   32'h46);

      // Test 5: reset mid-RUN aborts without a done pulse
      a2 = 8'hFF; b2 = 8'h01; mode2 = 1'b0; start2 = 1'b1;
      tick;
      start2 = 1'b0;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("t5_busy", 32'(busy2), 32'd0);
      chk("t5_done", 32'(done2), 32'd0);
      chk("t5_sum",  32'(sum2),  32'd0);
      chk("t5_lc",   32'(lc2),   32'd0);
      dcount = 0;
      for (int k = 0; k < 5; k++) begin
         tick; dcount += int'(done2) + int'(busy2);
      end
      chk("t5_no_done", 32'(dcount), 32'd0);
      op2("t5_fresh", 8'h0F, 8'h01, 1'b0, 8'h10, 2'b01);

      // Test 6: four-nibble instance
      op4("t6a", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1111);
`ifdef NIBBLE_SERIAL_ADDER_SAT_EN
      op4("t6b", 16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 4'b0001);
`else
      op4("t6b", 16'hFFFF, 16'h0001, 1'b1, 16'hFFF0, 4'b0001);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Parametrised, sequential successor to the combinational nibble adder. Adds two NIBBLES×4-bit operands one nibble per clock with a start/busy/done handshake. Two modes:
- mode 0: chained carry, a full-width add.
- mode 1: independent per-lane (SIMD) nibble adds.

Sits between operand registers and any consumer that tolerates a multi-cycle result in exchange for a single 4-bit adder.

Parameters:
NIBBLES, 2, number of 4-bit lanes; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
mode  input  1  0 = chained add, 1 = independent lanes; captured with start
A  input  W  operand A; captured with start
B  input  W  operand B; captured with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse, result valid
sum  output  W  result; nibble i = lane i
lane_cout  output  NIBBLES  carry out of each nibble stage
carry_out  output  1  equals lane_cout[NIBBLES-1]

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst). Reset is sampled on the clk rising edge only.
- Reset values:
  - State = IDLE; busy = 0, done = 0.
  - sum = 0, lane_cout = 0, carry_out = 0.
  - Internal nibble index = 0, carry register = 0.
- IDLE:
  - If start=1, capture A, B, mode; clear index and carry; clear sum and lane_cout; go to RUN.
  - If start=0, hold all outputs; the previous result stays readable.
- RUN: one nibble per cycle, index i = 0..NIBBLES-1.
  - t = A[4i+3:4i] + B[4i+3:4i] + cin, as a 5-bit value.
  - cin = carry register in mode 0; cin = 0 in mode 1.
  - sum[4i+3:4i] <= t[3:0]; lane_cout[i] <= t[4]; carry register <= t[4].
  - After i = NIBBLES-1, go to DONE.
- DONE: done=1 for exactly one cycle; busy=1; then go to IDLE.
- Latency:
  - Start sampled at edge 0.
  - Nibble 0 written at edge 1; nibble NIBBLES-1 written at edge NIBBLES.
  - done high during the cycle after edge NIBBLES+1. For NIBBLES=2: done high after edge 3.
- Start while busy (RUN or DONE) is ignored: no capture, no restart, no error flag. Back-to-back operation therefore needs at least one IDLE cycle; throughput is one op per NIBBLES+2 cycles.
- Operand changes on A/B/mode while busy have no effect; only the captured copy is used.
- sum nibbles above the current index read 0 during RUN. Consumers may sample sum only on done, or any time in IDLE.
- Mode 0 result: {carry_out, sum} = A + B, full W+1-bit, no truncation.
- Mode 1 result: per lane, {lane_cout[i], sum lane i} = A lane i + B lane i. No carry crosses lanes.
- Reset mid-operation (rst=1 in RUN or DONE): return to IDLE with reset values on the next edge. No done pulse is produced for the aborted op.
- rst has priority over start when both are high in the same cycle.

Optional Feature:
Macro NIBBLE_SERIAL_ADDER_SAT_EN.
- Defined: in mode 1, any lane with t[4]=1 writes sum lane = 4'hF (saturate); lane_cout[i] still reports 1 so overflow stays visible. Mode 0 is unaffected.
- Undefined: mode 1 lanes wrap modulo 16, as described in Behaviour.
- Latency, handshake and port list are identical in both builds.

Test Plan:
1. NIBBLES=2, A=8'hAA, B=8'h55, mode=0, start pulse → busy=1 for 3 cycles; done after edge 3; sum=8'hFF, carry_out=0, lane_cout=2'b00.
2. A=8'hFF, B=8'h01, mode=0 → sum=8'h00, lane_cout=2'b11, carry_out=1, i.e. {carry_out, sum} = 9'h100 (carry ripples across nibbles).
3. A=8'hCC, B=8'h33, mode=1 → sum=8'hFF, lane_cout=2'b00. Then A=8'hFF, B=8'h01, mode=1:
   - without SAT_EN: sum=8'hF0, lane_cout=2'b01, carry_out=0.
   - with SAT_EN: sum=8'hFF, lane_cout=2'b01.
4. Start A=8'h12, B=8'h34, mode 0; re-pulse start with A=8'hFF, B=8'hFF one cycle later → second start ignored; done once, sum=8'h46; next start accepted only from IDLE.
5. Start an op, assert rst for one cycle during RUN → next cycle busy=0, done=0, sum=0, lane_cout=0; no done pulse follows. A fresh start then completes normally.
6. NIBBLES=4, A=16'hFFFF, B=16'h0001, mode=0 → done after edge 5; sum=16'h0000, carry_out=1. Same operands in mode=1 → sum=16'hFFF0, lane_cout=4'b0001.
